// File: rtl/flash_cmd_sequencer.sv
// JEDEC command sequencer for an SST39SF-style parallel flash: unlock writes, program/erase,
// DQ7 data# polling with timeout abort, and single-byte reads. Owns the bus only while busy.
module flash_cmd_sequencer #(
    parameter int          WE_LOW_CYCLES = 2,
    parameter int          OE_LOW_CYCLES = 3,
    parameter logic [23:0] POLL_LIMIT    = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        bbc_lock,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [18:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        done,
    output logic        error,
    output logic [7:0]  rdata,
    output logic        bbc_allow,
    output logic [18:0] flash_A,
    output logic [7:0]  flash_D_out,
    output logic        flash_D_oe,
    input  logic [7:0]  flash_D_in,
    output logic        flash_nOE,
    output logic        flash_nWE
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_TURN       = 3'd1;
    localparam logic [2:0] S_WR_SETUP   = 3'd2;
    localparam logic [2:0] S_WR_PULSE   = 3'd3;
    localparam logic [2:0] S_WR_HOLD    = 3'd4;
    localparam logic [2:0] S_RD_PULSE   = 3'd5;
    localparam logic [2:0] S_RD_RECOVER = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    localparam logic [1:0] M_CMD   = 2'd0;
    localparam logic [1:0] M_POLL  = 2'd1;
    localparam logic [1:0] M_ABORT = 2'd2;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_PROGRAM = 2'd1;
    localparam logic [1:0] OP_SECTOR  = 2'd2;

    localparam logic [7:0] WE_LAST = 8'(WE_LOW_CYCLES - 1);
    localparam logic [7:0] OE_LAST = 8'(OE_LOW_CYCLES - 1);

    logic [2:0]  state, state_n;
    logic [1:0]  mode, mode_n;
    logic [2:0]  step, step_n;
    logic [7:0]  pulse_cnt, pulse_n;
    logic [23:0] poll_cnt, poll_n;
    logic [18:0] addr_n;
    logic [7:0]  data_n;
    logic        sample;
    logic [1:0]  op_r;
    logic [18:0] addr_r;
    logic [7:0]  wdata_r;
    logic [7:0]  dq;
    logic [2:0]  last_step;
    logic [18:0] poll_addr;
    logic        poll_ok;

    // {address, data} of each write in the unlock/command sequence
    function automatic logic [26:0] step_entry(input logic [1:0] op, input logic [2:0] idx,
                                               input logic [18:0] a, input logic [7:0] d);
        logic [26:0] e;
        e = {19'h05555, 8'hAA};
        case (idx)
            3'd0:    e = {19'h05555, 8'hAA};
            3'd1:    e = {19'h02AAA, 8'h55};
            3'd2:    e = (op == OP_PROGRAM) ? {19'h05555, 8'hA0} : {19'h05555, 8'h80};
            3'd3:    e = (op == OP_PROGRAM) ? {a, d} : {19'h05555, 8'hAA};
            3'd4:    e = {19'h02AAA, 8'h55};
            default: e = (op == OP_SECTOR) ? {a, 8'h30} : {19'h05555, 8'h10};
        endcase
        return e;
    endfunction

    assign last_step = (op_r == OP_PROGRAM) ? 3'd3 : 3'd5;
    assign poll_addr = (op_r == OP_SECTOR || op_r == OP_PROGRAM) ? addr_r : 19'h0;
    // Program completes when DQ7 shows true data; erase completes when DQ7 reads 1
    assign poll_ok   = dq[7] == ((op_r == OP_PROGRAM) ? wdata_r[7] : 1'b1);

    always_comb begin
        state_n = state;
        mode_n  = mode;
        step_n  = step;
        pulse_n = pulse_cnt;
        poll_n  = poll_cnt;
        addr_n  = flash_A;
        data_n  = flash_D_out;
        sample  = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) state_n = S_TURN;
            S_TURN: begin
                mode_n  = M_CMD;
                step_n  = 3'd0;
                pulse_n = 8'd0;
                poll_n  = 24'd0;
                if (op_r == OP_READ) begin
                    state_n = S_RD_PULSE;
                    addr_n  = addr_r;
                end else begin
                    state_n          = S_WR_SETUP;
                    {addr_n, data_n} = step_entry(op_r, 3'd0, addr_r, wdata_r);
                end
            end
            S_WR_SETUP: begin
                state_n = S_WR_PULSE;
                pulse_n = 8'd0;
            end
            S_WR_PULSE: begin
                if (pulse_cnt == WE_LAST) state_n = S_WR_HOLD;
                else pulse_n = pulse_cnt + 8'd1;
            end
            S_WR_HOLD: begin
                if (mode == M_ABORT) begin
                    state_n = S_DONE;
                end else if (step == last_step) begin
                    mode_n  = M_POLL;
                    state_n = S_RD_PULSE;
                    pulse_n = 8'd0;
                    poll_n  = poll_cnt + 24'd1;
                    addr_n  = poll_addr;
                end else begin
                    step_n           = step + 3'd1;
                    state_n          = S_WR_SETUP;
                    {addr_n, data_n} = step_entry(op_r, step + 3'd1, addr_r, wdata_r);
                end
            end
            S_RD_PULSE: begin
                if (pulse_cnt == OE_LAST) begin
                    state_n = S_RD_RECOVER;
                    sample  = 1'b1;
                end else begin
                    pulse_n = pulse_cnt + 8'd1;
                end
            end
            S_RD_RECOVER: begin
                if (mode == M_CMD || poll_ok) begin
                    state_n = S_DONE;
                end else if (poll_cnt == POLL_LIMIT) begin
                    mode_n  = M_ABORT;
                    state_n = S_WR_SETUP;
                    addr_n  = 19'h05555;
                    data_n  = 8'hF0;
                end else begin
                    state_n = S_RD_PULSE;
                    pulse_n = 8'd0;
                    poll_n  = poll_cnt + 24'd1;
                    addr_n  = poll_addr;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so pins track the state register exactly
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state       <= S_IDLE;
            mode        <= M_CMD;
            step        <= 3'd0;
            pulse_cnt   <= 8'd0;
            poll_cnt    <= 24'd0;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            rdata       <= 8'd0;
            bbc_allow   <= !bbc_lock;
            flash_A     <= 19'd0;
            flash_D_out <= 8'd0;
            flash_D_oe  <= 1'b0;
            flash_nOE   <= 1'b1;
            flash_nWE   <= 1'b1;
        end else begin
            state       <= state_n;
            mode        <= mode_n;
            step        <= step_n;
            pulse_cnt   <= pulse_n;
            poll_cnt    <= poll_n;
            cmd_ready   <= state_n == S_IDLE;
            done        <= state_n == S_DONE;
            error       <= (state_n == S_DONE) && (mode == M_ABORT);
            bbc_allow   <= (state_n == S_IDLE) && !bbc_lock;
            flash_A     <= addr_n;
            flash_D_out <= data_n;
            flash_D_oe  <= (state_n == S_WR_SETUP) || (state_n == S_WR_PULSE) || (state_n == S_WR_HOLD);
            flash_nOE   <= state_n != S_RD_PULSE;
            flash_nWE   <= state_n != S_WR_PULSE;
            if (state == S_RD_RECOVER && mode == M_CMD) rdata <= dq;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && cmd_valid) begin
            op_r    <= cmd_op;
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
        end
        if (sample) dq <= flash_D_in;
    end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: a flash status model on D, a bus-transaction monitor and
// per-cycle ownership rules, compared against directed command scenarios.
module tb_flash_cmd_sequencer;

    localparam int WE_LOW = 2;
    localparam int OE_LOW = 3;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        bbc_lock = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [18:0] cmd_addr = 19'd0;
    logic [7:0]  cmd_wdata = 8'd0;
    logic        cmd_ready, done, error, bbc_allow, flash_D_oe, flash_nOE, flash_nWE;
    logic [7:0]  rdata, flash_D_out, flash_D_in;
    logic [18:0] flash_A;

    // Flash model: the first busy_n reads of a scenario return busy status, later reads ready data
    int         reads_seen = 0;
    int         busy_n = 0;
    logic [7:0] busy_val = 8'h00;
    logic [7:0] ready_val = 8'h00;
    assign flash_D_in = (reads_seen <= busy_n) ? busy_val : ready_val;

    flash_cmd_sequencer #(
        .WE_LOW_CYCLES(WE_LOW),
        .OE_LOW_CYCLES(OE_LOW),
        .POLL_LIMIT   (24'd4)
    ) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .bbc_lock   (bbc_lock),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .done       (done),
        .error      (error),
        .rdata      (rdata),
        .bbc_allow  (bbc_allow),
        .flash_A    (flash_A),
        .flash_D_out(flash_D_out),
        .flash_D_oe (flash_D_oe),
        .flash_D_in (flash_D_in),
        .flash_nOE  (flash_nOE),
        .flash_nWE  (flash_nWE)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    bit          m_en = 1'b0;
    bit          m_idle = 1'b1;
    bit          m_lock_prev = 1'b0;
    int          we_run = 0;
    int          oe_run = 0;
    logic [18:0] we_a, oe_a;
    logic [7:0]  we_d;
    logic [26:0] wr_q[$];
    int          wr_len_q[$];
    logic [18:0] rd_addr_q[$];
    int          rd_len_q[$];
    logic [8:0]  done_q[$];
    logic [26:0] exp_wr[$];
    int          done_cyc = 0;
    int          accept_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Runs at each falling edge: ownership rules, bus transaction capture, busy/idle model
    task automatic monitor();
        if (m_en) begin
            check("cmd_ready vs idle", {31'd0, cmd_ready}, {31'd0, m_idle});
            check("bbc_allow vs idle&&!lock", {31'd0, bbc_allow}, {31'd0, m_idle && !m_lock_prev});
            check("nWE/nOE exclusive", {31'd0, !(flash_nWE === 1'b0 && flash_nOE === 1'b0)}, 32'd1);
            if (flash_nOE === 1'b0) check("D_oe during read", {31'd0, flash_D_oe}, 32'd0);
            if (flash_nWE === 1'b0) check("D_oe during write", {31'd0, flash_D_oe}, 32'd1);
            if (m_idle) check("idle pins nWE,nOE,D_oe,done", {28'd0, flash_nWE, flash_nOE, flash_D_oe, done}, 32'hC);
        end
        if (flash_nWE === 1'b0) begin
            we_run++;
            we_a = flash_A;
            we_d = flash_D_out;
        end else if (we_run > 0) begin
            wr_q.push_back({we_a, we_d});
            wr_len_q.push_back(we_run);
            we_run = 0;
        end
        if (flash_nOE === 1'b0) begin
            if (oe_run == 0) reads_seen++;
            oe_run++;
            oe_a = flash_A;
        end else if (oe_run > 0) begin
            rd_addr_q.push_back(oe_a);
            rd_len_q.push_back(oe_run);
            oe_run = 0;
        end
        if (done === 1'b1) begin
            done_q.push_back({error, rdata});
            done_cyc = cyc;
        end
        if (!nRESET) m_idle = 1'b1;
        else if (m_idle && cmd_valid) begin
            m_idle = 1'b0;
            accept_cyc = cyc + 1;
        end else if (done === 1'b1) m_idle = 1'b1;
        m_lock_prev = bbc_lock;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #2;
    endtask

    task automatic add_wr(input logic [18:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d,
                           input int bn, input logic [7:0] bv, input logic [7:0] rv, input bit disturb);
        wr_q.delete(); wr_len_q.delete(); rd_addr_q.delete(); rd_len_q.delete(); done_q.delete();
        reads_seen = 0; busy_n = bn; busy_val = bv; ready_val = rv;
        cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        if (disturb) begin
            cmd_op = 2'd0; cmd_addr = 19'h7FFFF; cmd_wdata = 8'h00;
        end
        for (int i = 0; i < 3000 && done_q.size() == 0; i++) begin
            if (disturb) begin
                if (i == 10) cmd_valid = 1'b1;
                if (i == 12) cmd_valid = 1'b0;
                if (i == 20) bbc_lock = 1'b1;
                if (i == 23) bbc_lock = 1'b0;
            end
            tick();
        end
        tick();
        tick();
        check("done pulse count", done_q.size(), 32'd1);
    endtask

    task automatic verify(input string tag, input int n_reads, input logic [18:0] raddr,
                          input logic err, input logic [7:0] rd);
        check({tag, " write count"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            check({tag, " write addr/data"}, {5'd0, wr_q[i]}, {5'd0, exp_wr[i]});
            check({tag, " nWE low cycles"}, wr_len_q[i], WE_LOW);
        end
        check({tag, " read count"}, rd_addr_q.size(), n_reads);
        for (int i = 0; i < rd_addr_q.size(); i++) begin
            check({tag, " read addr"}, {13'd0, rd_addr_q[i]}, {13'd0, raddr});
            check({tag, " nOE low cycles"}, rd_len_q[i], OE_LOW);
        end
        if (done_q.size() > 0) begin
            check({tag, " error"}, {31'd0, done_q[0][8]}, {31'd0, err});
            check({tag, " rdata"}, {24'd0, done_q[0][7:0]}, {24'd0, rd});
        end
    endtask

    initial begin
        repeat (2) tick();
        nRESET = 1'b1;
        m_en = 1'b1;
        check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset bbc_allow", {31'd0, bbc_allow}, 32'd1);
        check("reset nOE/nWE", {30'd0, flash_nOE, flash_nWE}, 32'd3);
        check("reset D_oe/done/error", {29'd0, flash_D_oe, done, error}, 32'd0);
        check("reset rdata", {24'd0, rdata}, 32'd0);
        check("reset flash_A", {13'd0, flash_A}, 32'd0);
        bbc_lock = 1'b1;
        tick();
        check("bbc_lock=1 allow", {31'd0, bbc_allow}, 32'd0);
        bbc_lock = 1'b0;
        tick();
        check("bbc_lock=0 allow", {31'd0, bbc_allow}, 32'd1);

        exp_wr.delete();
        run_cmd(2'd0, 19'h70F0F, 8'h00, 0, 8'h00, 8'h42, 1'b0);
        verify("read", 1, 19'h70F0F, 1'b0, 8'h42);
        check("read latency", done_cyc - accept_cyc, 32'd5);

        exp_wr.delete();
        add_wr(19'h05555, 8'hAA); add_wr(19'h02AAA, 8'h55); add_wr(19'h05555, 8'hA0);
        add_wr(19'h51234, 8'h89);
        run_cmd(2'd1, 19'h51234, 8'h89, 3, 8'h09, 8'h89, 1'b0);
        verify("program", 4, 19'h51234, 1'b0, 8'h42);

        exp_wr.delete();
        add_wr(19'h05555, 8'hAA); add_wr(19'h02AAA, 8'h55); add_wr(19'h05555, 8'h80);
        add_wr(19'h05555, 8'hAA); add_wr(19'h02AAA, 8'h55); add_wr(19'h12000, 8'h30);
        run_cmd(2'd2, 19'h12000, 8'h00, 2, 8'h00, 8'hFF, 1'b1);
        verify("sector_erase", 3, 19'h12000, 1'b0, 8'h42);
        check("bbc_allow after erase", {31'd0, bbc_allow}, 32'd1);

        exp_wr.delete();
        add_wr(19'h05555, 8'hAA); add_wr(19'h02AAA, 8'h55); add_wr(19'h05555, 8'h80);
        add_wr(19'h05555, 8'hAA); add_wr(19'h02AAA, 8'h55); add_wr(19'h05555, 8'h10);
        add_wr(19'h05555, 8'hF0);
        run_cmd(2'd3, 19'h3ABCD, 8'h00, 1000, 8'h00, 8'hFF, 1'b0);
        verify("poll_timeout", 4, 19'h00000, 1'b1, 8'h42);

        done_q.delete();
        reads_seen = 0; busy_n = 1000;
        cmd_op = 2'd1; cmd_addr = 19'h00100; cmd_wdata = 8'h11; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && flash_nWE !== 1'b0; i++) tick();
        check("reached write pulse", {31'd0, flash_nWE}, 32'd0);
        nRESET = 1'b0;
        tick();
        check("reset abort nWE", {31'd0, flash_nWE}, 32'd1);
        check("reset abort D_oe", {31'd0, flash_D_oe}, 32'd0);
        check("reset abort cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset abort rdata", {24'd0, rdata}, 32'd0);
        nRESET = 1'b1;
        repeat (10) tick();
        check("no done after reset abort", done_q.size(), 32'd0);

        exp_wr.delete();
        run_cmd(2'd0, 19'h00001, 8'h00, 0, 8'h00, 8'h5A, 1'b0);
        verify("read_after_reset", 1, 19'h00001, 1'b0, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
